playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
Sequences the auto-play datapath. Owns song selection, the note index into the song ROM, beat timing, the articulation gap, and play/pause/next/prev control. Drives the 5-bit note code consumed by the buzzer. Sits between the mode/button logic and the buzzer, replacing free-running song counters with an explicit controlled sequencer.

Parameters:
BEAT_CYCLES, 50000000, clk cycles per note at tempo 00 (0.5 s at 100 MHz)
GAP_DIV, 10, silent tail per beat = beat_len / GAP_DIV cycles
NOTE_W, 5, note code width (0 = rest)
IDX_W, 6, note index width
NUM_SONGS, 3, number of songs; song_sel wraps modulo NUM_SONGS
SONG_W, 2, song select width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  auto-play mode active; low forces IDLE
btn_play  in  1  single-cycle pulse, toggles play/pause
btn_next  in  1  single-cycle pulse, next song
btn_prev  in  1  single-cycle pulse, previous song
tempo  in  2  00 = 1x, 01 = fast (beat/2), 10 = slow (beat*2), 11 = treated as 00
rom_note  in  NOTE_W  combinational ROM note at (song_sel, note_idx)
song_len  in  IDX_W  combinational ROM note count for song_sel
song_sel  out  SONG_W  song select to ROM
note_idx  out  IDX_W  note address to ROM
note  out  NOTE_W  registered note to buzzer
playing  out  1  high in PLAY
beat_tick  out  1  one-cycle pulse on each note advance

Behaviour:
- All outputs are registered and reset to 0. State resets to IDLE.
- There is one clock domain. Reset is synchronous and active-high on rst. Clock is clk.
- States and transitions:
  - IDLE: btn_play goes to PLAY with idx=0 and beat_cnt=0.
  - PLAY: btn_play goes to PAUSE.
  - PAUSE: btn_play goes to PLAY. beat_cnt resumes from its frozen value.
  - enable=0 in any state goes to IDLE, with idx=0, beat_cnt=0, note=0.
- Priority, highest first: rst, !enable, next/prev, play.
  - next and prev asserted in the same cycle are both ignored.
  - play asserted together with next/prev is ignored.
- btn_next changes song_sel to (song_sel+1) mod NUM_SONGS. btn_prev changes song_sel to song_sel-1, wrapping 0 to NUM_SONGS-1.
- Both next and prev clear idx and beat_cnt. The current state is kept: IDLE stays IDLE and only the song changes.
- beat_len is latched from tempo at each beat start (beat_cnt==0). A tempo change mid-beat takes effect on the next beat.
- gap = beat_len / GAP_DIV (integer). beat_cnt is a 29-bit counter.
- In PLAY:
  - beat_cnt increments each cycle.
  - At beat_cnt == beat_len-1: beat_cnt goes to 0, idx advances, and beat_tick pulses for that cycle.
- Index wrap: when idx == song_len-1, the next index is 0 (loop the same song; see Optional Feature).
- song_len==0: idx holds at 0, note stays 0, and beat_tick still pulses.
- Note output:
  - In PLAY, note <= rom_note when beat_cnt < beat_len-gap, otherwise 0.
  - In IDLE and PAUSE, note <= 0.
  - Latency is 1 cycle from the idx/beat_cnt update to the note change.
- playing is registered, so it is valid one cycle after the state change.

Optional Feature:
AUTO_ADVANCE_EN
- Defined: the index wrap at end of song also advances song_sel (mod NUM_SONGS). idx goes to 0 and playback continues in PLAY.
- Undefined: the wrap loops the current song. song_sel changes only on next/prev.

Decomposition:
- A shared package `player_pkg` holds:
  - The note code width and the REST=0 constant.
  - The tempo encodings (TEMPO_1X, TEMPO_FAST, TEMPO_SLOW).
  - The state enum (IDLE/PLAY/PAUSE).
- One sub-module, `beat_timer`, is natural. It holds the latched beat_len, beat_cnt, the gap compare, and the tick generation, with freeze and clear inputs.
- The ROM stays external.

Test Plan:
All scenarios use BEAT_CYCLES=20, GAP_DIV=10, NUM_SONGS=3, and a stub ROM: song0 len 4 notes {8,12,13,0}, song1 len 2 {5,10}, song2 len 0.
1. rst, then enable=1 and btn_play: playing=1 next cycle. note=8 for cycles 1..18 and 0 for 2 cycles. beat_tick at cycle 20, idx=1, note=12.
2. Play song0 through 4 beats: idx sequence 0,1,2,3,0. The fourth note is a rest, so note=0 for the whole beat.
3. Pause at beat_cnt=7, hold 50 cycles, then resume: note=0 and idx frozen during the pause. The next beat_tick arrives 13 cycles after resume.
4. tempo=01 mid-beat: the current beat ends at 20, the next beat lasts 10 with gap 1. tempo=10 gives 40/4.
5. btn_next from song2 during PLAY: song_sel=0, idx=0, beat_cnt=0, still PLAY. btn_prev from 0 gives 2. Simultaneous next+prev gives no change.
6. Drop enable mid-note: the next cycle shows IDLE, note=0, idx=0, playing=0. With AUTO_ADVANCE_EN, the song0 wrap leaves song_sel=1.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the auto-play path: note width, rest code,
// tempo encodings, sequencer states and the tempo-to-beat-length mapping.
package player_pkg;

  localparam int NOTE_W = 5;
  localparam int BEAT_W = 29;

  localparam logic [NOTE_W-1:0] REST = '0;

  localparam logic [1:0] TEMPO_1X   = 2'b00;
  localparam logic [1:0] TEMPO_FAST = 2'b01;
  localparam logic [1:0] TEMPO_SLOW = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Encoding 11 is unused and plays at the nominal tempo.
  function automatic logic [BEAT_W-1:0] beatLenFor(input logic [1:0] tempo,
                                                   input logic [BEAT_W-1:0] base);
    logic [BEAT_W-1:0] len;
    case (tempo)
      TEMPO_FAST: len = base >> 1;
      TEMPO_SLOW: len = base << 1;
      default:    len = base;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat counter for the sequencer: latches the beat length at each beat start,
// flags the last cycle of a beat and the silent articulation tail.
module beat_timer #(
  parameter int BEAT_CYCLES = 50000000,
  parameter int GAP_DIV     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_tempo,
  input  logic       i_freeze,
  input  logic       i_clear,
  output logic       o_lastCycle,
  output logic       o_inGap
);
  import player_pkg::*;

  logic [BEAT_W-1:0] r_beatCnt;
  logic [BEAT_W-1:0] r_beatLen;
  logic [BEAT_W-1:0] w_curLen;
  logic [BEAT_W-1:0] w_gap;

  // At a beat start the tempo input is live, so a new tempo is seen on its first cycle.
  always_comb begin
    w_curLen = r_beatLen;
    if (r_beatCnt == '0) begin
      w_curLen = beatLenFor(i_tempo, BEAT_W'(BEAT_CYCLES));
    end
    w_gap = w_curLen / BEAT_W'(GAP_DIV);
  end

  assign o_lastCycle = (r_beatCnt == (w_curLen - BEAT_W'(1)));
  assign o_inGap     = (r_beatCnt >= (w_curLen - w_gap));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beatCnt <= '0;
      r_beatLen <= BEAT_W'(BEAT_CYCLES);
    end else begin
      if (r_beatCnt == '0) begin
        r_beatLen <= w_curLen;
      end
      if (i_clear) begin
        r_beatCnt <= '0;
      end else if (!i_freeze) begin
        r_beatCnt <= o_lastCycle ? '0 : r_beatCnt + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// Auto-play sequencer: song select, note index, play/pause/next/prev control.
// Define AUTO_ADVANCE_EN to move to the next song when the current one wraps.
module playback_sequencer #(
  parameter int BEAT_CYCLES = 50000000,
  parameter int GAP_DIV     = 10,
  parameter int NOTE_W      = player_pkg::NOTE_W,
  parameter int IDX_W       = 6,
  parameter int NUM_SONGS   = 3,
  parameter int SONG_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              btn_play,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [1:0]        tempo,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [IDX_W-1:0]  song_len,
  output logic [SONG_W-1:0] song_sel,
  output logic [IDX_W-1:0]  note_idx,
  output logic [NOTE_W-1:0] note,
  output logic              playing,
  output logic              beat_tick
);
  import player_pkg::*;

  state_e            r_state;
  state_e            w_nextState;
  logic [SONG_W-1:0] r_songSel;
  logic [IDX_W-1:0]  r_noteIdx;
  logic [NOTE_W-1:0] r_note;
  logic              r_playing;
  logic              r_beatTick;

  logic w_evNext;
  logic w_evPrev;
  logic w_songEv;
  logic w_playEv;
  logic w_start;
  logic w_clear;
  logic w_freeze;
  logic w_lastCycle;
  logic w_inGap;
  logic w_advance;
  logic w_emptySong;
  logic w_atEnd;
  logic [IDX_W-1:0] w_nextIdx;

  function automatic logic [SONG_W-1:0] songInc(input logic [SONG_W-1:0] s);
    return (s >= SONG_W'(NUM_SONGS - 1)) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] songDec(input logic [SONG_W-1:0] s);
    return (s == '0) ? SONG_W'(NUM_SONGS - 1) : s - SONG_W'(1);
  endfunction

  // Conflicting buttons cancel; play is dropped whenever a song button is pressed.
  assign w_evNext    = enable & btn_next & ~btn_prev;
  assign w_evPrev    = enable & btn_prev & ~btn_next;
  assign w_songEv    = w_evNext | w_evPrev;
  assign w_playEv    = enable & btn_play & ~(btn_next | btn_prev);
  assign w_start     = w_playEv & (r_state == IDLE);
  assign w_clear     = ~enable | w_songEv | w_start;
  assign w_freeze    = (r_state != PLAY) | w_playEv;
  assign w_advance   = enable & (r_state == PLAY) & ~w_songEv & ~w_playEv & w_lastCycle;
  assign w_emptySong = (song_len == '0);
  assign w_atEnd     = ~w_emptySong & (r_noteIdx >= (song_len - IDX_W'(1)));
  assign w_nextIdx   = (w_emptySong | w_atEnd) ? '0 : r_noteIdx + IDX_W'(1);

  beat_timer #(
    .BEAT_CYCLES (BEAT_CYCLES),
    .GAP_DIV     (GAP_DIV)
  ) u_beatTimer (
    .clk         (clk),
    .rst         (rst),
    .i_tempo     (tempo),
    .i_freeze    (w_freeze),
    .i_clear     (w_clear),
    .o_lastCycle (w_lastCycle),
    .o_inGap     (w_inGap)
  );

  always_comb begin
    w_nextState = r_state;
    if (!enable) begin
      w_nextState = IDLE;
    end else if (w_playEv) begin
      case (r_state)
        IDLE:    w_nextState = PLAY;
        PLAY:    w_nextState = PAUSE;
        PAUSE:   w_nextState = PLAY;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // playing follows the next state so it drops on the same edge enable falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_songSel  <= '0;
      r_noteIdx  <= '0;
      r_note     <= '0;
      r_playing  <= 1'b0;
      r_beatTick <= 1'b0;
    end else begin
      r_playing  <= (w_nextState == PLAY);
      r_beatTick <= w_advance;

      if (w_clear) begin
        r_noteIdx <= '0;
      end else if (w_advance) begin
        r_noteIdx <= w_nextIdx;
      end

      if (w_songEv) begin
        r_songSel <= w_evNext ? songInc(r_songSel) : songDec(r_songSel);
      end
`ifdef AUTO_ADVANCE_EN
      else if (w_advance && w_atEnd) begin
        r_songSel <= songInc(r_songSel);
      end
`endif

      if (enable && (r_state == PLAY) && !w_emptySong && !w_inGap) begin
        r_note <= rom_note;
      end else begin
        r_note <= NOTE_W'(REST);
      end
    end
  end

  assign song_sel  = r_songSel;
  assign note_idx  = r_noteIdx;
  assign note      = r_note;
  assign playing   = r_playing;
  assign beat_tick = r_beatTick;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed table-driven bench for playback_sequencer with a stub song ROM
// (song0 {8,12,13,0}, song1 {5,10}, song2 empty) and a 20-cycle beat.
module tb_playback_sequencer;

  localparam int BEAT_CYCLES = 20;
  localparam int GAP_DIV     = 10;
  localparam int NOTE_W      = 5;
  localparam int IDX_W       = 6;
  localparam int NUM_SONGS   = 3;
  localparam int SONG_W      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              btnPlay;
  logic              btnNext;
  logic              btnPrev;
  logic [1:0]        tempo;
  logic [NOTE_W-1:0] romNote;
  logic [IDX_W-1:0]  songLen;
  logic [SONG_W-1:0] songSel;
  logic [IDX_W-1:0]  noteIdx;
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              beatTick;

  int checksRun    = 0;
  int checksPassed = 0;

  typedef struct {
    logic              en;
    logic              play;
    logic              next;
    logic              prev;
    logic [1:0]        tempo;
    int                cycles;
    logic [SONG_W-1:0] expSong;
    logic [IDX_W-1:0]  expIdx;
    logic [NOTE_W-1:0] expNote;
    logic              expPlaying;
    logic              expTick;
  } vec_t;

  vec_t vecs[$];

  playback_sequencer #(
    .BEAT_CYCLES (BEAT_CYCLES),
    .GAP_DIV     (GAP_DIV),
    .NOTE_W      (NOTE_W),
    .IDX_W       (IDX_W),
    .NUM_SONGS   (NUM_SONGS),
    .SONG_W      (SONG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .btn_play  (btnPlay),
    .btn_next  (btnNext),
    .btn_prev  (btnPrev),
    .tempo     (tempo),
    .rom_note  (romNote),
    .song_len  (songLen),
    .song_sel  (songSel),
    .note_idx  (noteIdx),
    .note      (note),
    .playing   (playing),
    .beat_tick (beatTick)
  );

  always #5 clk = ~clk;

  // Stub ROM answering combinationally for the selected song and index.
  always_comb begin
    romNote = '0;
    songLen = '0;
    case (songSel)
      2'd0: begin
        songLen = 6'd4;
        case (noteIdx)
          6'd0:    romNote = 5'd8;
          6'd1:    romNote = 5'd12;
          6'd2:    romNote = 5'd13;
          default: romNote = 5'd0;
        endcase
      end
      2'd1: begin
        songLen = 6'd2;
        case (noteIdx)
          6'd0:    romNote = 5'd5;
          6'd1:    romNote = 5'd10;
          default: romNote = 5'd0;
        endcase
      end
      default: begin
        songLen = 6'd0;
        romNote = 5'd0;
      end
    endcase
  end

  task automatic addVec(input logic en, input logic play, input logic next, input logic prev,
                        input logic [1:0] tmp, input int cycles,
                        input logic [SONG_W-1:0] expSong, input logic [IDX_W-1:0] expIdx,
                        input logic [NOTE_W-1:0] expNote, input logic expPlaying,
                        input logic expTick);
    vec_t v;
    v.en = en; v.play = play; v.next = next; v.prev = prev; v.tempo = tmp;
    v.cycles = cycles; v.expSong = expSong; v.expIdx = expIdx; v.expNote = expNote;
    v.expPlaying = expPlaying; v.expTick = expTick;
    vecs.push_back(v);
  endtask

  task automatic checkField(input string name, input int act, input int exp);
    checksRun++;
    if (act == exp) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [SONG_W-1:0] expSong,
                             input logic [IDX_W-1:0] expIdx, input logic [NOTE_W-1:0] expNote,
                             input logic expPlaying, input logic expTick);
    checkField({tag, ".song_sel"},  int'(songSel),  int'(expSong));
    checkField({tag, ".note_idx"},  int'(noteIdx),  int'(expIdx));
    checkField({tag, ".note"},      int'(note),     int'(expNote));
    checkField({tag, ".playing"},   int'(playing),  int'(expPlaying));
    checkField({tag, ".beat_tick"}, int'(beatTick), int'(expTick));
  endtask

  // Entered and left at a negative edge; buttons are held for the first rising edge only.
  task automatic applyStimulus(input vec_t v);
    enable  = v.en;
    btnPlay = v.play;
    btnNext = v.next;
    btnPrev = v.prev;
    tempo   = v.tempo;
    for (int k = 0; k < v.cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      btnPlay = 1'b0;
      btnNext = 1'b0;
      btnPrev = 1'b0;
    end
  endtask

  initial begin
    logic [SONG_W-1:0] wrapSong;
`ifdef AUTO_ADVANCE_EN
    wrapSong = 2'd1;
`else
    wrapSong = 2'd0;
`endif

    //      en pl nx pv tmp  n    song idx note play tick
    addVec(1, 1, 0, 0, 2'd0, 1,   0, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 0,  8, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 17,  0, 0,  8, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 1,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 1, 12, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 19,  0, 2,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 2, 13, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 20,  0, 3,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 10,  0, 3,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 9,   0, 0,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 0,  8, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 6,   0, 0,  8, 1, 0);
    // pause at beat count 7, hold, resume
    addVec(1, 1, 0, 0, 2'd0, 2,   0, 0,  0, 0, 0);
    addVec(1, 0, 0, 0, 2'd0, 50,  0, 0,  0, 0, 0);
    addVec(1, 1, 0, 0, 2'd0, 1,   0, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 12,  0, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 1,   0, 1,  0, 1, 1);
    // fast tempo mid-beat, then slow
    addVec(1, 0, 0, 0, 2'd0, 5,   0, 1, 12, 1, 0);
    addVec(1, 0, 0, 0, 2'd1, 15,  0, 2,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd1, 1,   0, 2, 13, 1, 0);
    addVec(1, 0, 0, 0, 2'd1, 8,   0, 2, 13, 1, 0);
    addVec(1, 0, 0, 0, 2'd1, 1,   0, 3,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd2, 1,   0, 3,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd2, 38,  0, 3,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd2, 1,   0, 0,  0, 1, 1);
    addVec(1, 0, 0, 0, 2'd2, 36,  0, 0,  8, 1, 0);
    addVec(1, 0, 0, 0, 2'd2, 1,   0, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 3,   0, 1,  0, 1, 1);
    // song navigation while playing, including the empty song
    addVec(1, 0, 0, 1, 2'd0, 1,   2, 0, 12, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 3,   2, 0,  0, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 17,  2, 0,  0, 1, 1);
    addVec(1, 0, 1, 0, 2'd0, 1,   0, 0,  0, 1, 0);
    addVec(1, 0, 1, 1, 2'd0, 1,   0, 0,  8, 1, 0);
    addVec(1, 1, 1, 0, 2'd0, 1,   1, 0,  8, 1, 0);
    addVec(1, 0, 0, 0, 2'd0, 1,   1, 0,  5, 1, 0);
    // enable drop and navigation in IDLE
    addVec(0, 0, 0, 0, 2'd0, 1,   1, 0,  0, 0, 0);
    addVec(1, 0, 0, 0, 2'd0, 3,   1, 0,  0, 0, 0);
    addVec(1, 0, 1, 0, 2'd0, 1,   2, 0,  0, 0, 0);
    addVec(1, 0, 0, 1, 2'd0, 1,   1, 0,  0, 0, 0);
    addVec(1, 0, 0, 1, 2'd0, 1,   0, 0,  0, 0, 0);
    // four full beats of song0 ending on the wrap tick
    addVec(1, 1, 0, 0, 2'd0, 81,  wrapSong, 0, 0, 1, 1);

    rst     = 1'b1;
    enable  = 1'b0;
    btnPlay = 1'b0;
    btnNext = 1'b0;
    btnPrev = 1'b0;
    tempo   = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", 2'd0, 6'd0, 5'd0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i), vecs[i].expSong, vecs[i].expIdx, vecs[i].expNote,
                  vecs[i].expPlaying, vecs[i].expTick);
    end

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
